// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR-flash target.
package spi_flash_pkg;

  localparam int SPI_W  = 8;
  localparam int DATA_W = 32;

  localparam logic [SPI_W-1:0] CMD_READ    = 8'h01;
  localparam logic [SPI_W-1:0] CMD_WRITE   = 8'h02;
  localparam logic [SPI_W-1:0] CMD_READ_ID = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_t;

  // State entered once the command byte has been received.
  function automatic state_t decode_cmd(input logic [SPI_W-1:0] cmd);
    case (cmd)
      CMD_READ, CMD_WRITE: return ADDR;
      CMD_READ_ID:         return ID;
      default:             return IGNORE;
    endcase
  endfunction

  // Byte of a word in transmit order: sel 0 is the most significant byte.
  function automatic logic [SPI_W-1:0] byte_of(input logic [DATA_W-1:0] word,
                                               input logic [1:0]        sel);
    case (sel)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end: brings the SPI pins into the p_clk domain and
// turns the synchronised s_clk / s_css levels into single-cycle edge pulses.
module spi_edge_sync
  import spi_flash_pkg::*;
(
  input  logic             p_clk,
  input  logic             p_reset,
  input  logic             s_clk,
  input  logic             s_css,
  input  logic [SPI_W-1:0] s_mosi,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             css_fall,
  output logic             css_rise,
  output logic [SPI_W-1:0] mosi
);

  // [0] and [1] are the synchroniser pair, [2] is the edge-detect history.
  logic [2:0]       sclk_q;
  logic [2:0]       css_q;
  logic [SPI_W-1:0] mosi_q1;
  logic [SPI_W-1:0] mosi_q2;

  // Shift all three pins through equal-length synchronisers so mosi stays
  // aligned with the s_clk edge that qualifies it. Chip select resets to
  // the deasserted level so leaving reset never fakes a frame start.
  always_ff @(posedge p_clk) begin
    // NOTE: non-blocking assignments make every flop sample the old value
    // of its neighbour, which is what turns this into a shift chain.
    if (p_reset) begin
      sclk_q  <= '0;
      css_q   <= '1;
      mosi_q1 <= '0;
      mosi_q2 <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], s_clk};
      css_q   <= {css_q[1:0], s_css};
      mosi_q1 <= s_mosi;
      mosi_q2 <= mosi_q1;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign css_fall  = ~css_q[1] & css_q[2];
  assign css_rise  = css_q[1] & ~css_q[2];
  assign mosi      = mosi_q2;

endmodule

// File: rtl/spi_norflash_target.sv
// SPI NOR-flash responder: decodes command/address/data frames, keeps a
// small word memory and streams read or ID data back on s_miso.
module spi_norflash_target
  import spi_flash_pkg::*;
#(
  parameter int                DEPTH   = 16,
  parameter logic [DATA_W-1:0] ID_WORD = 32'hEF40_1800
) (
  input  logic             p_clk,
  input  logic             p_reset,
  input  logic             s_clk,
  input  logic             s_css,
  input  logic [SPI_W-1:0] s_mosi,
  output logic [SPI_W-1:0] s_miso,
  output logic             cmd_err,
  output logic             frame_active
);

  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  logic             sclk_rise, sclk_fall, css_fall, css_rise;
  logic [SPI_W-1:0] mosi;

  state_t state, next_state;

  // Strobes decoded from state and pin edges.
  logic cmd_take;   // command byte arrives
  logic addr_take;  // address byte arrives
  logic addr_last;  // third address byte arrives
  logic wr_take;    // write data byte arrives
  logic rd_shift;   // next read byte goes out
  logic id_shift;   // next ID byte goes out

  logic        is_read;
  logic [1:0]  byte_cnt;
  idx_t        idx;
  idx_t        idx_in;
  logic [23:0] wr_sr;
  logic        wr_en;
  idx_t        wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic        rd_en;
  idx_t        rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  spi_edge_sync u_sync (
    .p_clk     (p_clk),
    .p_reset   (p_reset),
    .s_clk     (s_clk),
    .s_css     (s_css),
    .s_mosi    (s_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .css_fall  (css_fall),
    .css_rise  (css_rise),
    .mosi      (mosi)
  );

  // Only the low address bits select a word, so shifting each address byte
  // into a register of index width leaves exactly A[IDX_W-1:0] after slot 3.
  assign idx_in = idx_t'({idx, mosi});

  // State register.
  always_ff @(posedge p_clk) begin
    if (p_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a chip-select release ends any frame.
  always_comb begin
    next_state = state;
    if (css_rise) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (css_fall) next_state = sclk_rise ? decode_cmd(mosi) : CMD;
        CMD:     if (sclk_rise) next_state = decode_cmd(mosi);
        ADDR:    if (sclk_rise && byte_cnt == 2'd2) next_state = DATA;
        default: ;
      endcase
    end
  end

  // Outputs and datapath strobes. A rise in the same sampled cycle as the
  // chip-select fall is already slot 0, hence the IDLE command take.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    frame_active = (state != IDLE);
    cmd_take     = 1'b0;
    addr_take    = 1'b0;
    addr_last    = 1'b0;
    wr_take      = 1'b0;
    rd_shift     = 1'b0;
    id_shift     = 1'b0;
    if (!css_rise) begin
      unique case (state)
        IDLE: cmd_take = css_fall && sclk_rise;
        CMD:  cmd_take = sclk_rise;
        ADDR: begin
          addr_take = sclk_rise;
          addr_last = sclk_rise && (byte_cnt == 2'd2);
        end
        DATA: begin
          wr_take  = !is_read && sclk_rise;
          rd_shift = is_read && sclk_fall;
        end
        ID:      id_shift = sclk_fall;
        default: ;
      endcase
    end
    cmd_err = cmd_take && (decode_cmd(mosi) == IGNORE);
  end

  // Read port control: first word at the end of the address, the following
  // word as soon as the last byte of the current one has been sent.
  assign rd_en   = (addr_last && is_read) || (rd_shift && byte_cnt == 2'd3);
  assign rd_addr = addr_last ? idx_in : idx + idx_t'(1);

  // Frame datapath: byte counting, address capture, write assembly and
  // s_miso byte selection.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      is_read  <= 1'b0;
      byte_cnt <= '0;
      idx      <= '0;
      wr_sr    <= '0;
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
      s_miso   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (css_fall || css_rise) begin
        byte_cnt <= '0;
        s_miso   <= '0;
      end
      if (cmd_take) begin
        is_read  <= (mosi == CMD_READ);
        byte_cnt <= '0;
      end
      if (addr_take) begin
        idx      <= idx_in;
        byte_cnt <= addr_last ? 2'd0 : byte_cnt + 2'd1;
      end
      if (wr_take) begin
        wr_sr    <= {wr_sr[15:0], mosi};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wr_en   <= 1'b1;
          wr_data <= {wr_sr, mosi};
          wr_idx  <= idx;
          idx     <= idx + idx_t'(1);
        end
      end
      if (rd_shift) begin
        s_miso   <= byte_of(rd_word, byte_cnt);
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) idx <= idx + idx_t'(1);
      end
      if (id_shift) begin
        s_miso   <= byte_of(ID_WORD, byte_cnt);
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // Word memory with one write port and a registered read port.
  // NOTE: the array is deliberately left out of reset; its contents must
  // survive p_reset and a reset term would stop it mapping onto RAM.
  always_ff @(posedge p_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_word <= mem[rd_addr];
  end

endmodule

// File: tb/tb_spi_norflash_target.sv
// Randomised and directed bench for spi_norflash_target: a reference model
// predicts s_miso for every byte slot, a monitor compares on each s_clk rise.
`timescale 1ns/1ps
module tb_spi_norflash_target;

  localparam int          DEPTH   = 16;
  localparam logic [31:0] ID_WORD = 32'hEF40_1800;
  localparam int          H       = 8;  // p_clk cycles per s_clk phase

  typedef logic [7:0] bq_t[$];

  logic       p_clk = 1'b0;
  logic       p_reset = 1'b1;
  logic       s_clk = 1'b0;
  logic       s_css = 1'b1;
  logic [7:0] s_mosi = 8'h00;
  logic [7:0] s_miso;
  logic       cmd_err;
  logic       frame_active;

  int         n_cmp = 0;
  int         n_err = 0;
  int         err_pulses = 0;
  logic [7:0] exp_q[$];
  logic [31:0] ref_mem [DEPTH];

  spi_norflash_target #(.DEPTH(DEPTH), .ID_WORD(ID_WORD)) dut (
    .p_clk        (p_clk),
    .p_reset      (p_reset),
    .s_clk        (s_clk),
    .s_css        (s_css),
    .s_mosi       (s_mosi),
    .s_miso       (s_miso),
    .cmd_err      (cmd_err),
    .frame_active (frame_active)
  );

  always #5 p_clk = ~p_clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count cycles with cmd_err high, sampled mid-cycle.
  always @(negedge p_clk) if (cmd_err) err_pulses++;

  // Monitor: every s_clk rise inside a frame must present the predicted byte.
  always @(posedge s_clk) begin
    logic [7:0] e;
    if (!s_css) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL miso_slot: unpredicted slot, got %02h", s_miso);
      end else begin
        e = exp_q.pop_front();
        check("miso_slot", s_miso, e);
      end
    end
  end

  // Reference model: predicts s_miso for each slot from the frame's bytes
  // and applies completed write words to the model memory.
  task automatic model_frame(input bq_t b, output int err_exp);
    int          n, idx, k;
    logic [7:0]  cmd;
    logic [31:0] w;
    n   = b.size();
    cmd = b[0];
    idx = (n >= 4) ? int'(b[3]) % DEPTH : 0;
    err_exp = (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h9F) ? 0 : 1;
    for (int s = 0; s < n; s++) begin
      logic [7:0] e;
      e = 8'h00;
      if (cmd == 8'h01 && s >= 4) begin
        k = s - 4;
        w = ref_mem[(idx + k / 4) % DEPTH];
        e = w[31 - 8 * (k % 4) -: 8];
      end else if (cmd == 8'h9F && s >= 1) begin
        k = s - 1;
        e = ID_WORD[31 - 8 * (k % 4) -: 8];
      end
      exp_q.push_back(e);
    end
    if (cmd == 8'h02 && n >= 8)
      for (int i = 0; i < (n - 4) / 4; i++)
        ref_mem[(idx + i) % DEPTH] = {b[4 + 4 * i], b[5 + 4 * i], b[6 + 4 * i], b[7 + 4 * i]};
  endtask

  // Drive one complete frame; fast=1 drops s_css and raises s_clk together.
  task automatic drive_frame(input bq_t b, input bit fast);
    int err_exp, err_before, start;
    model_frame(b, err_exp);
    err_before = err_pulses;
    start = 0;
    @(negedge p_clk);
    s_css = 1'b0;
    if (fast) begin
      s_mosi = b[0];
      s_clk  = 1'b1;
      repeat (H) @(negedge p_clk);
      s_clk = 1'b0;
      start = 1;
    end
    for (int i = start; i < b.size(); i++) begin
      s_mosi = b[i];
      repeat (H) @(negedge p_clk);
      s_clk = 1'b1;
      repeat (H) @(negedge p_clk);
      s_clk = 1'b0;
    end
    repeat (H) @(negedge p_clk);
    check("frame_active_busy", frame_active, 1);
    s_css = 1'b1;
    repeat (6) @(negedge p_clk);
    check("cmd_err_cycles", err_pulses - err_before, err_exp);
    check("miso_after_frame", s_miso, 0);
    check("frame_active_after", frame_active, 0);
  endtask

  task automatic spi_byte(input logic [7:0] v);
    s_mosi = v;
    repeat (H) @(negedge p_clk);
    s_clk = 1'b1;
    repeat (H) @(negedge p_clk);
    s_clk = 1'b0;
  endtask

  initial begin
    bq_t b;
    int  err_before;
    logic [7:0] c;

    repeat (4) @(negedge p_clk);
    p_reset = 1'b0;
    @(negedge p_clk);
    check("reset_miso", s_miso, 0);
    check("reset_cmd_err", cmd_err, 0);
    check("reset_frame_active", frame_active, 0);

    // Write then read back.
    drive_frame('{8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}, 1'b0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);

    // Burst write wrapping from the last word to word 0.
    drive_frame('{8'h02, 8'h00, 8'h00, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88}, 1'b0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    // Burst read across the wrap in one frame.
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);

    // Aborted write leaves the stored word intact.
    drive_frame('{8'h02, 8'h00, 8'h00, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5}, 1'b0);
    drive_frame('{8'h02, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hAD}, 1'b0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);

    // READ_ID repeats the ID word; unknown command pulses cmd_err once.
    drive_frame('{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    drive_frame('{8'h7E, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);

    // Aborts during the address phase have no side effects.
    drive_frame('{8'h01, 8'h00}, 1'b0);
    drive_frame('{8'h02, 8'h00, 8'h00}, 1'b0);

    // s_clk activity with chip select high is ignored.
    err_before = err_pulses;
    repeat (3) begin
      s_mosi = 8'h7E;
      repeat (H) @(negedge p_clk);
      s_clk = 1'b1;
      repeat (H) @(negedge p_clk);
      s_clk = 1'b0;
    end
    repeat (4) @(negedge p_clk);
    check("idle_clk_frame_active", frame_active, 0);
    check("idle_clk_cmd_err", err_pulses - err_before, 0);

    // Chip-select fall and s_clk rise in the same sampled cycle.
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
    drive_frame('{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);

    // Reset during the second address byte of a READ.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    @(negedge p_clk);
    s_css = 1'b0;
    spi_byte(8'h01);
    spi_byte(8'h00);
    s_mosi = 8'h00;
    repeat (H) @(negedge p_clk);
    s_clk = 1'b1;
    repeat (4) @(negedge p_clk);
    p_reset = 1'b1;
    @(negedge p_clk);
    check("midreset_miso", s_miso, 0);
    check("midreset_frame_active", frame_active, 0);
    s_css = 1'b1;
    s_clk = 1'b0;
    repeat (4) @(negedge p_clk);
    p_reset = 1'b0;
    repeat (4) @(negedge p_clk);
    check("postreset_frame_active", frame_active, 0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    drive_frame('{8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);

    // Random phase: fill the whole memory, then mixed random frames.
    b = '{8'h02, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom_range(255)));
    drive_frame(b, 1'b0);
    for (int t = 0; t < 45; t++) begin
      int kind;
      kind = int'($urandom_range(4));
      b = {};
      case (kind)
        0, 1: begin
          b.push_back((kind == 0) ? 8'h02 : 8'h01);
          for (int i = 0; i < 3; i++) b.push_back(8'($urandom_range(255)));
          for (int i = 0; i < int'($urandom_range(12)); i++) b.push_back(8'($urandom_range(255)));
        end
        2: begin
          b.push_back(8'h9F);
          for (int i = 0; i < int'($urandom_range(9)); i++) b.push_back(8'($urandom_range(255)));
        end
        3: begin
          do c = 8'($urandom_range(255));
          while (c == 8'h01 || c == 8'h02 || c == 8'h9F);
          b.push_back(c);
          for (int i = 0; i < int'($urandom_range(4)); i++) b.push_back(8'($urandom_range(255)));
        end
        default: begin
          b.push_back(($urandom_range(1) == 0) ? 8'h01 : 8'h02);
          for (int i = 0; i < int'($urandom_range(2)); i++) b.push_back(8'($urandom_range(255)));
        end
      endcase
      drive_frame(b, 1'($urandom_range(1)));
    end

    check("leftover_expected_slots", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
